// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multiplier request sequencer and its operand FIFO.
package mult_seq_pkg;

   localparam int DATA_W_DEFAULT  = 64;
   localparam int PROD_W          = 2 * DATA_W_DEFAULT;
   localparam int MULT_CYCLES     = 64;
   localparam int TIMEOUT_DEFAULT = 80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_t;

   // Width of a counter or pointer that must hold values 0..max_val-1; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/mult_seq_fifo.sv
// Operand FIFO for the multiplier sequencer; count, full and empty are registered so in_ready is a clean flop output.
module mult_seq_fifo
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = 2 * DATA_W_DEFAULT,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = cnt_width(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + 1'b1;
      end else if (do_pop && !do_push) begin
         count_next = count - 1'b1;
      end
   end

   // NOTE: storage has no reset; only the pointers and flags decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
         count <= count_next;
         full  <= (count_next == CNT_FULL);
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/mult_req_sequencer.sv
// Sequences buffered operand pairs through the shift-add multiplier core: clear, load, wait for done, capture the product.
module mult_req_sequencer
   import mult_seq_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEFAULT,
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_a,
   input  logic [DATA_W-1:0]   in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*DATA_W-1:0] out_product,
   output logic                mult_rst_n,
   output logic                mult_w_en,
   output logic [DATA_W-1:0]   mult_a,
   output logic [DATA_W-1:0]   mult_b,
   input  logic                mult_ok,
   input  logic [2*DATA_W-1:0] mult_product,
   output logic                busy,
   output logic                timeout_err
);

   localparam int RUN_W = cnt_width(TIMEOUT);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

   state_t                state;
   logic [RUN_W-1:0]      run_cnt;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic [2*DATA_W-1:0]   fifo_head;

   mult_seq_fifo #(
      .WIDTH (2 * DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid),
      .push_data ({in_a, in_b}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
   assign busy     = (state != ST_IDLE) || !fifo_empty;

   // Core strobes default to their inactive levels each cycle; the state that needs a pulse overrides them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         run_cnt     <= '0;
         mult_rst_n  <= 1'b0;
         mult_w_en   <= 1'b0;
         mult_a      <= '0;
         mult_b      <= '0;
         out_valid   <= 1'b0;
         out_product <= '0;
         timeout_err <= 1'b0;
      end else begin
         mult_rst_n <= 1'b1;
         mult_w_en  <= 1'b0;

         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  {mult_a, mult_b} <= fifo_head;
                  mult_rst_n       <= 1'b0;
                  state            <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               mult_w_en <= 1'b1;
               state     <= ST_LOAD;
            end
            ST_LOAD: begin
               run_cnt <= '0;
               state   <= ST_RUN;
            end
            ST_RUN: begin
               if (mult_ok) begin
                  state <= ST_DONE;
               end else if (run_cnt == RUN_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  run_cnt <= run_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               // The core keeps its product while done, so waiting here for a free output slot is safe.
               if (!out_valid || out_ready) begin
                  out_product <= mult_product;
                  out_valid   <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_req_sequencer.sv
// Self-checking bench for mult_req_sequencer with a behavioural 64-cycle multiplier core model.
module tb_mult_req_sequencer;
   import mult_seq_pkg::*;

   localparam int DW          = 64;
   localparam int DEPTH       = 2;
   localparam int TMO         = 80;
   localparam int PW          = 2 * DW;
   localparam int NOMINAL_LAT = 69;
   localparam int OP_PERIOD   = 68;
   localparam int N_RAND      = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_product;
   logic          mult_rst_n;
   logic          mult_w_en;
   logic [DW-1:0] mult_a;
   logic [DW-1:0] mult_b;
   logic          mult_ok;
   logic [PW-1:0] mult_product;
   logic          busy;
   logic          timeout_err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [PW-1:0] p;
   } vec_t;

   logic [PW-1:0] exp_q [$];
   logic [PW-1:0] got_p [$];
   int            got_t [$];
   int            n_delivered;

   mult_req_sequencer #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_product  (out_product),
      .mult_rst_n   (mult_rst_n),
      .mult_w_en    (mult_w_en),
      .mult_a       (mult_a),
      .mult_b       (mult_b),
      .mult_ok      (mult_ok),
      .mult_product (mult_product),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: loads on the strobe, raises done 64 cycles later and holds it until its reset.
   logic          core_dead = 1'b0;
   logic          core_busy;
   int            core_cnt;
   logic [PW-1:0] core_prod;

   always @(posedge clk) begin
      if (!mult_rst_n) begin
         core_busy    <= 1'b0;
         core_cnt     <= 0;
         mult_ok      <= 1'b0;
         mult_product <= '0;
      end else if (mult_w_en) begin
         core_busy <= 1'b1;
         core_cnt  <= MULT_CYCLES - 1;
         core_prod <= PW'(mult_a) * PW'(mult_b);
      end else if (core_busy && !core_dead) begin
         if (core_cnt == 1) begin
            mult_ok      <= 1'b1;
            mult_product <= core_prod;
            core_busy    <= 1'b0;
         end
         core_cnt <= core_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " in_ready"}, PW'(in_ready), PW'(1));
      check({tag, " out_valid"}, PW'(out_valid), PW'(0));
      check({tag, " out_product"}, out_product, '0);
      check({tag, " mult_rst_n"}, PW'(mult_rst_n), PW'(0));
      check({tag, " mult_w_en"}, PW'(mult_w_en), PW'(0));
      check({tag, " mult_a/b"}, PW'({mult_a, mult_b}), '0);
      check({tag, " busy"}, PW'(busy), PW'(0));
      check({tag, " timeout_err"}, PW'(timeout_err), PW'(0));
   endtask

   // Presents one operand pair until accepted; t_acc is the cycle count just after the accepting edge.
   task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] b, output int t_acc);
      int guard = 0;
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      while (!in_ready && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check("push accepted", PW'(in_ready), PW'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      t_acc    = cyc;
   endtask

   // Single operation from an idle block: product, latency and the core strobe pattern.
   task automatic run_one(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [PW-1:0] exp_p);
      int            t0;
      int            lat = -1;
      int            rst_cnt = 0;
      int            rst_at = -1;
      int            wen_cnt = 0;
      int            wen_at = -1;
      logic [PW-1:0] got = '0;
      push_op(a, b, t0);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!mult_rst_n) begin
            rst_cnt++;
            rst_at = cyc - t0 + 1;
         end
         if (mult_w_en) begin
            wen_cnt++;
            wen_at = cyc - t0 + 1;
         end
         if (out_valid) begin
            lat = cyc - t0 + 1;
            got = out_product;
            break;
         end
      end
      check({name, " product"}, got, exp_p);
      check({name, " latency"}, PW'(lat), PW'(NOMINAL_LAT));
      check({name, " mult_rst_n pulse {count,cycle}"}, PW'({rst_cnt, rst_at}), PW'({32'd1, 32'd2}));
      check({name, " mult_w_en pulse {count,cycle}"}, PW'({wen_cnt, wen_at}), PW'({32'd1, 32'd3}));
      @(negedge clk);
      check({name, " out_valid consumed"}, PW'(out_valid), PW'(0));
      check({name, " idle afterwards"}, PW'(busy), PW'(0));
   endtask

   // Records accepted results, sampling at the current negedge first; bounded by budget cycles.
   task automatic collect(input int n_want, input int budget);
      got_p.delete();
      got_t.delete();
      for (int n = 0; n < budget && got_p.size() < n_want; n++) begin
         if (out_valid && out_ready) begin
            got_p.push_back(out_product);
            got_t.push_back(cyc);
         end
         @(negedge clk);
      end
   endtask

   task automatic pad_got(input int n);
      while (got_p.size() < n) begin
         got_p.push_back('0);
         got_t.push_back(0);
      end
   endtask

   task automatic rand_driver();
      for (int i = 0; i < N_RAND; i++) begin
         logic [DW-1:0] a;
         logic [DW-1:0] b;
         int            guard;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a = '1;
         if ($urandom_range(0, 5) == 0) b = '0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         @(negedge clk);
         in_a     = a;
         in_b     = b;
         in_valid = 1'b1;
         guard    = 0;
         while (!in_ready && guard < 400) begin
            @(negedge clk);
            guard++;
         end
         check("rand push accepted", PW'(in_ready), PW'(1));
         if (in_ready) exp_q.push_back(PW'(a) * PW'(b));
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic rand_monitor();
      int budget = N_RAND * 150 + 400;
      n_delivered = 0;
      for (int n = 0; n < budget && n_delivered < N_RAND; n++) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready) begin
            n_delivered++;
            check("rand result expected", PW'(exp_q.size() != 0), PW'(1));
            if (exp_q.size() != 0) check("rand result product", out_product, exp_q.pop_front());
         end
      end
      check("rand all delivered", PW'(n_delivered), PW'(N_RAND));
      out_ready = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [6];
      int   t0;
      int   t1;
      int   first_te;
      int   saw_ov;

      vecs[0] = '{64'd3, 64'd5, 128'd15};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
      vecs[2] = '{64'd0, 64'hDEAD_BEEF_0123_4567, 128'd0};
      vecs[3] = '{64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
      vecs[4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001};
      vecs[5] = '{64'd1, 64'h0123_4567_89AB_CDEF, 128'h0123_4567_89AB_CDEF};

      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;

      // Reset values, then release.
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      check("mult_rst_n low until first edge", PW'(mult_rst_n), PW'(0));
      @(posedge clk);
      #1;
      check("mult_rst_n high after first edge", PW'(mult_rst_n), PW'(1));

      for (int i = 0; i < 6; i++) begin
         run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
      end

      // Three back-to-back pushes; the fourth attempt meets a full FIFO.
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 64'd2;
      in_b     = 64'd3;
      @(posedge clk);
      #1;
      t0 = cyc;
      @(negedge clk);
      check("burst push2 in_ready", PW'(in_ready), PW'(1));
      in_a = 64'd4;
      in_b = 64'd5;
      @(posedge clk);
      @(negedge clk);
      check("burst push3 in_ready", PW'(in_ready), PW'(1));
      in_a = 64'd6;
      in_b = 64'd7;
      @(posedge clk);
      @(negedge clk);
      check("burst push4 in_ready low when full", PW'(in_ready), PW'(0));
      in_a = 64'd8;
      in_b = 64'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      collect(4, 320);
      check("burst result count", PW'(got_p.size()), PW'(3));
      pad_got(3);
      check("burst result0", got_p[0], 128'd6);
      check("burst result1", got_p[1], 128'd20);
      check("burst result2", got_p[2], 128'd42);
      check("burst first latency", PW'(got_t[0] - t0 + 1), PW'(NOMINAL_LAT));
      check("burst spacing 0-1", PW'(got_t[1] - got_t[0]), PW'(OP_PERIOD));
      check("burst spacing 1-2", PW'(got_t[2] - got_t[1]), PW'(OP_PERIOD));

      // Output back-pressure across two operations.
      out_ready = 1'b0;
      push_op(64'd10, 64'd10, t0);
      push_op(64'd11, 64'd11, t1);
      repeat (200) @(negedge clk);
      check("bp first result held valid", PW'(out_valid), PW'(1));
      check("bp first result held product", out_product, 128'd100);
      check("bp second op waiting (busy)", PW'(busy), PW'(1));
      out_ready = 1'b1;
      collect(2, 10);
      check("bp delivered count", PW'(got_p.size()), PW'(2));
      pad_got(2);
      check("bp delivered first", got_p[0], 128'd100);
      check("bp delivered second", got_p[1], 128'd121);
      check("bp back-to-back delivery", PW'(got_t[1] - got_t[0]), PW'(1));
      check("bp out_valid drained", PW'(out_valid), PW'(0));
      check("bp idle afterwards", PW'(busy), PW'(0));

      // Randomized operands and back-pressure against a queue of expected products.
      fork
         rand_driver();
         rand_monitor();
      join
      repeat (2) @(negedge clk);
      check("rand idle afterwards", PW'(busy), PW'(0));

      // Core that never finishes: timeout on the 80th RUN cycle.
      core_dead = 1'b1;
      push_op(64'd5, 64'd5, t0);
      first_te = -1;
      saw_ov   = 0;
      for (int n = 0; n < 120; n++) begin
         @(negedge clk);
         if (timeout_err && first_te < 0) first_te = cyc - t0 + 1;
         if (out_valid) saw_ov = 1;
      end
      check("timeout first visible cycle", PW'(first_te), PW'(4 + TMO));
      check("timeout no out_valid", PW'(saw_ov), PW'(0));
      check("timeout back to idle", PW'(busy), PW'(0));
      core_dead = 1'b0;
      run_one("after timeout 7x9", 64'd7, 64'd9, 128'd63);
      check("timeout_err sticky", PW'(timeout_err), PW'(1));

      // Reset in RUN cycle 30 with a second operation still queued.
      push_op(64'd12, 64'd13, t0);
      push_op(64'd14, 64'd15, t1);
      while (cyc - t0 + 1 < 33) @(negedge clk);
      check("pre-reset operation in flight", PW'(busy), PW'(1));
      reset = 1'b1;
      #1;
      check_reset_values("mid-op reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid-op reset mult_rst_n released", PW'(mult_rst_n), PW'(1));
      saw_ov = 0;
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         if (out_valid || busy) saw_ov = 1;
      end
      check("mid-op reset dropped all work", PW'(saw_ov), PW'(0));
      run_one("after reset 7x9", 64'd7, 64'd9, 128'd63);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
